psone_pad_bridge: RTL and testbench
===================================

Name: psone_pad_bridge

Overview:
- Bridges a PlayStation (PS1) digital/analog gamepad to a PC serial link.
- A push-button toggles continuous polling. While polling is enabled, the block runs 9-byte PS1 exchanges on the pad's SPI-like bus (LSB first).
- After each exchange it sends the 9 received bytes, in order, out of an 8N1 UART transmitter.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency.
- PAD_HALF_DIV, 100, system clocks per oCLK half-period (250 kHz pad clock).
- BAUD_DIV, 434, system clocks per UART bit (115200 baud).
- BYTE_GAP, 500, system clocks between bytes with oCS held low.
- POLL_GAP, 50_000, system clocks idle between frames while polling is enabled.
- NBYTES, 9, bytes exchanged per frame.

Ports:
- iCLK in 1 system clock; all logic on rising edge.
- iRESET in 1 synchronous reset, active-low.
- iKEY_ST in 1 start/stop key, active high. First press starts polling, second press stops it.
- oCS out 1 pad attention/select, active low.
- oCLK out 1 pad clock, idles high.
- oMOSI out 1 command data to pad.
- iMISO in 1 pad data.
- iACK in 1 pad acknowledge. Synchronised and ignored; reserved.
- iRX in 1 UART receive. Unused; tie-off tolerated.
- oTX out 1 UART transmit, idles high.

Behaviour:
- Reset (iRESET low at a clock edge) values:
  - oCS=1, oCLK=1, oMOSI=1, oTX=1.
  - polling disabled; cnt_byte=0, cnt_edge=0; state IDLE.
- Key handling:
  - 2-flop synchroniser, then rising-edge detect.
  - Each detected edge toggles run_en.
  - Clearing run_en lets the current frame and its UART dump finish, then the block stays in IDLE.
- States: IDLE, SEL (oCS low, wait PAD_HALF_DIV), XFER, GAP, DESEL, DUMP, WAIT.
- Transitions:
  - IDLE->SEL when run_en=1.
  - XFER->GAP after edge 16 while cnt_byte<NBYTES-1; GAP->XFER after BYTE_GAP clocks with cnt_byte+1.
  - XFER->DESEL after edge 16 of byte NBYTES-1.
  - DESEL: oCS=1 after PAD_HALF_DIV clocks.
  - DUMP->WAIT after the last stop bit.
  - WAIT->SEL after POLL_GAP if run_en, else ->IDLE.
- Byte transfer (XFER), edge counter cnt_edge 1..16:
  - cnt_edge increments every PAD_HALF_DIV clocks; it is 0 outside XFER.
  - Odd cnt_edge: oCLK falls; oMOSI drives command bit (cnt_edge-1)>>1.
  - Even cnt_edge: oCLK rises; iMISO is sampled into bit (cnt_edge-1)>>1 of the receive shift register.
- Bit order: LSB first in both directions.
- cnt_byte:
  - 0..NBYTES-1, names the byte in flight.
  - Never exceeds NBYTES-1; it is 0 in IDLE.
- Command bytes: byte0=0x01, byte1=0x42, bytes 2..8=0x00.
- Buffering: each received byte is stored in a 9-entry buffer at index cnt_byte after edge 16.
- DUMP: transmits buffer[0..8] in order.
  - Framing: start bit 0, 8 data bits LSB first, stop bit 1, each bit BAUD_DIV clocks.
  - Next byte starts immediately after the stop bit.
- The buffer is frozen during DUMP. A new frame starts only after DUMP completes.
- A key press mid-frame never truncates a frame or a UART byte.
- Reset mid-frame aborts immediately to the reset values; the partial frame is not transmitted.

Test Plan:
- Reset, then pulse iKEY_ST for 1 clock; pad returns FF 73 5A 12 34 56 78 9A BC, driving each bit at cnt_byte/bit (cnt_edge-1)>>1 -> oCS falls; 9×16 oCLK edges; oMOSI sends 01 42 00…; UART receiver gets FF,73,5A,12,34,56,78,9A,BC in order with no framing errors.
- Continuous polling with the same pad data -> frames repeat after POLL_GAP; each frame's UART dump matches the same 9 bytes.
- Second key press during frame 2 -> frame 2 completes and its 9 bytes are transmitted; then IDLE with oCS=1, oCLK=1, oTX=1 and no further frames.
- Check oCLK idles high, each low/high phase lasts PAD_HALF_DIV clocks, and oCS stays low across BYTE_GAP.
- Reset asserted mid-byte 4 -> next clock oCS=1, oCLK=1, oTX=1, cnt_byte=0; nothing transmitted; the next key press starts a clean frame.
- Key held high for 1000 clocks -> exactly one toggle.

Source files
------------

// File: rtl/psone_pad_bridge.sv
// PS1 gamepad to UART bridge.
// A start/stop key toggles continuous polling; each poll runs one multi-byte
// exchange on the pad bus (LSB first) and then dumps the received bytes as 8N1.
module psone_pad_bridge #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int PAD_HALF_DIV = 100,
    parameter int BAUD_DIV     = 434,
    parameter int BYTE_GAP     = 500,
    parameter int POLL_GAP     = 50_000,
    parameter int NBYTES       = 9
) (
    input  logic iCLK,
    input  logic iRESET,
    input  logic iKEY_ST,
    output logic oCS,
    output logic oCLK,
    output logic oMOSI,
    input  logic iMISO,
    input  logic iACK,
    input  logic iRX,
    output logic oTX
);
    localparam int              BW        = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0]   LAST_BYTE = BW'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEL, S_XFER, S_GAP, S_DESEL, S_DUMP, S_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [1:0]      r_key_s;
    logic            r_key_d;
    logic            r_run_en;
    logic [1:0]      r_miso_s;
    logic [1:0]      r_ack_s;
    logic [31:0]     r_tmr;
    logic [31:0]     w_limit;
    logic            w_tick;
    logic [4:0]      r_edge;
    logic [BW-1:0]   r_byte;
    logic            w_last_byte;
    logic [7:0]      w_cmd;
    logic [7:0]      r_shift;
    logic [7:0]      r_buf [NBYTES];
    logic [3:0]      r_bit;
    logic [BW-1:0]   r_idx;
    logic            r_cs;
    logic            w_cs_nxt;
    logic            r_clk;
    logic            r_mosi;
    logic            r_tx;
    logic            w_unused;

    // iACK and iRX are reserved inputs; CLK_HZ only documents the divider basis
    assign w_unused    = ^{r_ack_s[1], iRX, (CLK_HZ > 0)};
    assign w_last_byte = (r_byte == LAST_BYTE);

    assign oCS   = r_cs;
    assign oCLK  = r_clk;
    assign oMOSI = r_mosi;
    assign oTX   = r_tx;

    // Key synchroniser and rising-edge toggle of the polling enable
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_key_s  <= 2'b00;
            r_key_d  <= 1'b0;
            r_run_en <= 1'b0;
        end else begin
            r_key_s <= {r_key_s[0], iKEY_ST};
            r_key_d <= r_key_s[1];
            if (r_key_s[1] && !r_key_d) begin
                r_run_en <= !r_run_en;
            end
        end
    end

    // Pad-side input synchronisers (data path, no reset needed)
    always_ff @(posedge iCLK) begin
        r_miso_s <= {r_miso_s[0], iMISO};
        r_ack_s  <= {r_ack_s[0], iACK};
    end

    // Per-state interval length and end-of-interval strobe
    always_comb begin
        w_limit = 32'(PAD_HALF_DIV);
        case (r_state)
            S_GAP:   w_limit = 32'(BYTE_GAP);
            S_DUMP:  w_limit = 32'(BAUD_DIV);
            S_WAIT:  w_limit = 32'(POLL_GAP);
            default: w_limit = 32'(PAD_HALF_DIV);
        endcase
        w_tick = (r_tmr == (w_limit - 32'd1));
    end

    // Interval timer restarts on every state change and every strobe
    always_ff @(posedge iCLK) begin
        if (!iRESET || (r_state == S_IDLE) || (w_state_nxt != r_state) || w_tick) begin
            r_tmr <= 32'd0;
        end else begin
            r_tmr <= r_tmr + 32'd1;
        end
    end

    // State register
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (r_run_en) w_state_nxt = S_SEL;
            S_SEL:   if (w_tick) w_state_nxt = S_XFER;
            S_XFER:  if (w_tick && (r_edge == 5'd16)) w_state_nxt = w_last_byte ? S_DESEL : S_GAP;
            S_GAP:   if (w_tick) w_state_nxt = S_XFER;
            S_DESEL: if (w_tick) w_state_nxt = S_DUMP;
            S_DUMP:  if (w_tick && (r_bit == 4'd9) && (r_idx == LAST_BYTE)) w_state_nxt = S_WAIT;
            S_WAIT:  if (w_tick) w_state_nxt = r_run_en ? S_SEL : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode: select is held low from SEL through DESEL; command byte by index
    always_comb begin
        w_cs_nxt = 1'b1;
        case (w_state_nxt)
            S_SEL, S_XFER, S_GAP, S_DESEL: w_cs_nxt = 1'b0;
            default:                       w_cs_nxt = 1'b1;
        endcase
        if (r_byte == BW'(0)) begin
            w_cmd = 8'h01;
        end else if (r_byte == BW'(1)) begin
            w_cmd = 8'h42;
        end else begin
            w_cmd = 8'h00;
        end
    end

    // Pad bus: select, clock edges 1..16, command bits and byte index
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_cs   <= 1'b1;
            r_clk  <= 1'b1;
            r_mosi <= 1'b1;
            r_edge <= 5'd0;
            r_byte <= '0;
        end else begin
            r_cs <= w_cs_nxt;
            case (r_state)
                S_XFER: begin
                    if (w_tick) begin
                        if (r_edge == 5'd16) begin
                            r_edge <= 5'd0;
                            r_mosi <= 1'b1;
                            if (w_last_byte) begin
                                r_byte <= '0;
                            end
                        end else begin
                            r_edge <= r_edge + 5'd1;
                            // next edge odd -> clock falls and a new command bit goes out
                            r_clk  <= r_edge[0];
                            if (!r_edge[0]) begin
                                r_mosi <= w_cmd[r_edge[3:1]];
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (w_tick) begin
                        r_byte <= r_byte + BW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Receive shift register and frame buffer (written only during XFER)
    always_ff @(posedge iCLK) begin
        if ((r_state == S_XFER) && w_tick) begin
            if (r_edge == 5'd16) begin
                r_buf[r_byte] <= r_shift;
            end else if (r_edge[0]) begin
                r_shift[r_edge[3:1]] <= r_miso_s[1];
            end
        end
    end

    // UART 8N1 transmitter walking the frozen buffer
    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            r_tx  <= 1'b1;
            r_bit <= 4'd0;
            r_idx <= '0;
        end else if ((r_state == S_DESEL) && w_tick) begin
            r_tx  <= 1'b0;
            r_bit <= 4'd0;
            r_idx <= '0;
        end else if ((r_state == S_DUMP) && w_tick) begin
            if (r_bit == 4'd9) begin
                if (r_idx == LAST_BYTE) begin
                    r_tx <= 1'b1;
                end else begin
                    r_idx <= r_idx + BW'(1);
                    r_bit <= 4'd0;
                    r_tx  <= 1'b0;
                end
            end else begin
                r_bit <= r_bit + 4'd1;
                r_tx  <= (r_bit == 4'd8) ? 1'b1 : r_buf[r_idx][r_bit[2:0]];
            end
        end
    end

endmodule

// File: tb/tb_psone_pad_bridge.sv
// Bench for psone_pad_bridge: pad model, UART receiver, expected-byte queue.
module tb_psone_pad_bridge;
    localparam int HALF  = 4;
    localparam int BAUD  = 8;
    localparam int BGAP  = 12;
    localparam int PGAP  = 40;
    localparam int NB    = 9;

    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    logic iKEY_ST = 1'b0;
    logic iMISO = 1'b1;
    logic iACK = 1'b0;
    logic iRX = 1'b1;
    logic oCS, oCLK, oMOSI, oTX;

    always #5 iCLK = ~iCLK;

    psone_pad_bridge #(
        .CLK_HZ(50_000_000), .PAD_HALF_DIV(HALF), .BAUD_DIV(BAUD),
        .BYTE_GAP(BGAP), .POLL_GAP(PGAP), .NBYTES(NB)
    ) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iKEY_ST(iKEY_ST),
        .oCS(oCS), .oCLK(oCLK), .oMOSI(oMOSI), .iMISO(iMISO),
        .iACK(iACK), .iRX(iRX), .oTX(oTX)
    );

    int total = 0;
    int bad = 0;
    int rx_count = 0;
    int mosi_count = 0;
    int frames_started = 0;
    int pbyte = 0;
    int pbit = 0;
    int edges = 0;
    int pat_sel = 0;
    logic run_en_m = 1'b0;
    logic prev_ok = 1'b0;
    logic abort = 1'b0;
    logic [7:0] rx_log [64];
    logic [7:0] mosi_log [64];
    logic [7:0] exp_q [$];
    logic [7:0] patA [NB] = '{8'hFF, 8'h73, 8'h5A, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    logic [7:0] patB [NB] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h01, 8'h80, 8'hC3, 8'h3C, 8'h7E};

    function automatic logic [7:0] pad_byte(input int sel, input int idx);
        return (sel != 0) ? patB[idx] : patA[idx];
    endfunction

    function automatic logic [7:0] cmd_exp(input int idx);
        if (idx == 0) return 8'h01;
        if (idx == 1) return 8'h42;
        return 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, req, $time);
        end
    endtask

    // Pad model: answers with the selected pattern, checks command bytes, books completed frames
    initial begin
        logic cs_p, clk_p;
        logic [7:0] msh, tmp;
        cs_p = 1'b1; clk_p = 1'b1; msh = 8'h00;
        forever begin
            @(oCS or oCLK);
            if (cs_p === 1'b1 && oCS === 1'b0) begin
                pbyte = 0; pbit = 0; edges = 0;
                frames_started++;
                chk("start_when_enabled", 32'(run_en_m), 32'd1);
            end else if (cs_p === 1'b0 && oCS === 1'b1) begin
                if (iRESET) begin
                    chk("frame_edges", edges, 2 * 8 * NB);
                    for (int i = 0; i < NB; i++) exp_q.push_back(pad_byte(pat_sel, i));
                    prev_ok = run_en_m;
                end else begin
                    prev_ok = 1'b0;
                end
            end
            if (oCS === 1'b0 && clk_p === 1'b1 && oCLK === 1'b0) begin
                edges++;
                if (pbyte < NB) begin
                    tmp = pad_byte(pat_sel, pbyte);
                    iMISO = tmp[pbit];
                end
            end
            if (oCS === 1'b0 && clk_p === 1'b0 && oCLK === 1'b1) begin
                edges++;
                msh[pbit] = oMOSI;
                pbit++;
                if (pbit == 8) begin
                    chk("mosi_byte", 32'(msh), 32'(cmd_exp(pbyte)));
                    if (mosi_count < 64) mosi_log[mosi_count] = msh;
                    mosi_count++;
                    pbyte++;
                    pbit = 0;
                end
            end
            cs_p = oCS; clk_p = oCLK;
        end
    end

    // UART receiver: mid-bit sampling, framing checks, compare against expected queue
    initial begin
        logic [7:0] b;
        wait (iRESET === 1'b1);
        forever begin
            @(negedge iCLK);
            if (oTX === 1'b0) begin
                repeat (BAUD / 2 - 1) @(negedge iCLK);
                chk("rx_start_bit", 32'(oTX), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (BAUD) @(negedge iCLK);
                    b[i] = oTX;
                end
                repeat (BAUD) @(negedge iCLK);
                chk("rx_stop_bit", 32'(oTX), 32'd1);
                if (rx_count < 64) rx_log[rx_count] = b;
                rx_count++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rx_unexpected actual=%0h required=none", b);
                end else begin
                    chk("rx_byte", 32'(b), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Cycle checker: clock idles high while deselected, low phases, poll spacing
    initial begin
        int lo_run, hi_run;
        logic cs_p, clk_p;
        wait (iRESET === 1'b1);
        lo_run = 0; hi_run = 0; cs_p = 1'b1; clk_p = 1'b1;
        forever begin
            @(negedge iCLK);
            if (oCS === 1'b1) chk("clk_idle_high", 32'(oCLK), 32'd1);
            if (oCLK === 1'b0) begin
                lo_run++;
            end else begin
                if (clk_p === 1'b0 && !abort) chk("clk_low_phase", lo_run, HALF);
                lo_run = 0;
            end
            if (oCS === 1'b1) begin
                hi_run++;
            end else begin
                // 9 bytes x 10 bits x 8 clocks + 40 idle clocks
                if (cs_p === 1'b1 && prev_ok && !abort) chk("poll_gap", hi_run, 32'd760);
                hi_run = 0;
            end
            cs_p = oCS; clk_p = oCLK;
        end
    end

    task automatic press_key();
        @(negedge iCLK);
        run_en_m = !run_en_m;
        iKEY_ST = 1'b1;
        @(negedge iCLK);
        iKEY_ST = 1'b0;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k;
        k = 0;
        while (rx_count < n && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        chk("wait_rx", 32'(rx_count >= n), 32'd1);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_started < n && k < budget) begin
            @(negedge iCLK);
            k++;
        end
        chk("wait_frame", 32'(frames_started >= n), 32'd1);
    endtask

    task automatic check_idle(input string nm);
        chk({nm, "_cs"}, 32'(oCS), 32'd1);
        chk({nm, "_clk"}, 32'(oCLK), 32'd1);
        chk({nm, "_tx"}, 32'(oTX), 32'd1);
        chk({nm, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        int k;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_cs", 32'(oCS), 32'd1);
        chk("rst_clk", 32'(oCLK), 32'd1);
        chk("rst_mosi", 32'(oMOSI), 32'd1);
        chk("rst_tx", 32'(oTX), 32'd1);
        @(negedge iCLK);
        iRESET = 1'b1;
        repeat (20) @(negedge iCLK);
        chk("idle_no_frame", frames_started, 0);

        // frame 1
        press_key();
        wait_rx(9, 3000);
        chk("f1_b0", 32'(rx_log[0]), 32'hFF);
        chk("f1_b1", 32'(rx_log[1]), 32'h73);
        chk("f1_b8", 32'(rx_log[8]), 32'hBC);
        chk("f1_mosi0", 32'(mosi_log[0]), 32'h01);
        chk("f1_mosi1", 32'(mosi_log[1]), 32'h42);
        chk("f1_mosi2", 32'(mosi_log[2]), 32'h00);

        // frame 2 repeats on its own; stop requested mid-frame
        wait_frames(2, 500);
        repeat (100) @(negedge iCLK);
        press_key();
        wait_rx(18, 3000);
        chk("f2_b4", 32'(rx_log[13]), 32'h34);
        chk("f2_b8", 32'(rx_log[17]), 32'hBC);
        repeat (2000) @(negedge iCLK);
        chk("stopped_frames", frames_started, 2);
        chk("stopped_rx", rx_count, 18);
        check_idle("stopped");

        // key held for 1000 clocks counts as a single press
        @(negedge iCLK);
        run_en_m = !run_en_m;
        iKEY_ST = 1'b1;
        repeat (1000) @(negedge iCLK);
        iKEY_ST = 1'b0;
        wait_frames(3, 100);
        wait_rx(27, 4000);
        chk("f3_b2", 32'(rx_log[20]), 32'h5A);

        // reset in the middle of byte 4 of frame 4
        wait_frames(4, 500);
        k = 0;
        while (!(pbyte == 4 && pbit == 3) && k < 2000) begin
            @(negedge iCLK);
            k++;
        end
        chk("reach_byte4", 32'(pbyte == 4 && pbit == 3), 32'd1);
        abort = 1'b1;
        iRESET = 1'b0;
        run_en_m = 1'b0;
        @(posedge iCLK);
        #1;
        chk("abort_cs", 32'(oCS), 32'd1);
        chk("abort_clk", 32'(oCLK), 32'd1);
        chk("abort_tx", 32'(oTX), 32'd1);
        chk("abort_mosi", 32'(oMOSI), 32'd1);
        @(negedge iCLK);
        iRESET = 1'b1;
        repeat (2000) @(negedge iCLK);
        abort = 1'b0;
        chk("abort_frames", frames_started, 4);
        chk("abort_rx", rx_count, 27);
        check_idle("abort");

        // clean frame with new pad data, stop requested during it
        pat_sel = 1;
        press_key();
        wait_frames(5, 100);
        repeat (50) @(negedge iCLK);
        press_key();
        wait_rx(36, 3000);
        chk("f5_b0", 32'(rx_log[27]), 32'hA5);
        chk("f5_b3", 32'(rx_log[30]), 32'hFF);
        chk("f5_b8", 32'(rx_log[35]), 32'h7E);
        chk("f5_mosi0", 32'(mosi_log[31]), 32'h01);
        chk("f5_mosi1", 32'(mosi_log[32]), 32'h42);
        repeat (2000) @(negedge iCLK);
        chk("final_frames", frames_started, 5);
        chk("final_rx", rx_count, 36);
        check_idle("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
